// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data-memory port.
// One access at a time: IDLE samples requests, BUSY holds the latched command
// until mem_ready or timeout, DONE pulses the granted requester's done.
module dmem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                p0_req,
   input  logic                p0_we,
   input  logic [ADDR_W-1:0]   p0_addr,
   input  logic [DATA_W-1:0]   p0_wdata,
   input  logic [DATA_W/8-1:0] p0_wmask,
   output logic                p0_done,
   output logic                p0_err,
   output logic [DATA_W-1:0]   p0_rdata,
   input  logic                p1_req,
   input  logic                p1_we,
   input  logic [ADDR_W-1:0]   p1_addr,
   input  logic [DATA_W-1:0]   p1_wdata,
   input  logic [DATA_W/8-1:0] p1_wmask,
   output logic                p1_done,
   output logic                p1_err,
   output logic [DATA_W-1:0]   p1_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready
);

   localparam int unsigned CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_grant_q, last_grant_d;
   logic                grant_q, grant_d;
   logic                cmd_we_q, cmd_we_d;
   logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
   logic [DATA_W/8-1:0] cmd_wmask_q, cmd_wmask_d;
   logic                mem_req_q, mem_req_d;
   logic                p0_done_q, p0_done_d;
   logic                p1_done_q, p1_done_d;
   logic                p0_err_q, p0_err_d;
   logic                p1_err_q, p1_err_d;
   logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
   logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
   logic                win;
   logic                hit_limit;
   logic [DATA_W-1:0]   ld_data;

   // Next-state, arbitration and registered-output computation
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      cmd_we_d     = cmd_we_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_wdata_d  = cmd_wdata_q;
      cmd_wmask_d  = cmd_wmask_q;
      mem_req_d    = 1'b0;
      p0_done_d    = 1'b0;
      p1_done_d    = 1'b0;
      p0_err_d     = 1'b0;
      p1_err_d     = 1'b0;
      p0_rdata_d   = '0;
      p1_rdata_d   = '0;
      // on a tie the port that was not granted last wins
      win          = p0_req ? (p1_req & ~last_grant_q) : p1_req;
      hit_limit    = ((cnt_q + CNT_W'(1)) == CNT_MAX);
      ld_data      = cmd_we_q ? '0 : mem_rdata;

      case (state_q)
         IDLE: begin
            if (p0_req || p1_req) begin
               state_d      = BUSY;
               grant_d      = win;
               last_grant_d = win;
               cnt_d        = '0;
               mem_req_d    = 1'b1;
               cmd_we_d     = win ? p1_we    : p0_we;
               cmd_addr_d   = win ? p1_addr  : p0_addr;
               cmd_wdata_d  = win ? p1_wdata : p0_wdata;
               cmd_wmask_d  = win ? p1_wmask : p0_wmask;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               state_d    = DONE;
               p0_done_d  = ~grant_q;
               p1_done_d  = grant_q;
               p0_rdata_d = grant_q ? '0 : ld_data;
               p1_rdata_d = grant_q ? ld_data : '0;
            end else if (hit_limit) begin
               state_d   = DONE;
               p0_done_d = ~grant_q;
               p1_done_d = grant_q;
               p0_err_d  = ~grant_q;
               p1_err_d  = grant_q;
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
               mem_req_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         cmd_we_q     <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         cmd_wmask_q  <= '0;
         mem_req_q    <= 1'b0;
         p0_done_q    <= 1'b0;
         p1_done_q    <= 1'b0;
         p0_err_q     <= 1'b0;
         p1_err_q     <= 1'b0;
         p0_rdata_q   <= '0;
         p1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         cmd_we_q     <= cmd_we_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
         cmd_wmask_q  <= cmd_wmask_d;
         mem_req_q    <= mem_req_d;
         p0_done_q    <= p0_done_d;
         p1_done_q    <= p1_done_d;
         p0_err_q     <= p0_err_d;
         p1_err_q     <= p1_err_d;
         p0_rdata_q   <= p0_rdata_d;
         p1_rdata_q   <= p1_rdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = cmd_we_q;
   assign mem_addr  = cmd_addr_q;
   assign mem_wdata = cmd_wdata_q;
   assign mem_wmask = cmd_wmask_q;
   assign p0_done   = p0_done_q;
   assign p1_done   = p1_done_q;
   assign p0_err    = p0_err_q;
   assign p1_err    = p1_err_q;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p0_req = 1'b0, p0_we = 1'b0;
   logic [31:0] p0_addr = '0, p0_wdata = '0;
   logic [3:0]  p0_wmask = '0;
   logic        p1_req = 1'b0, p1_we = 1'b0;
   logic [31:0] p1_addr = '0, p1_wdata = '0;
   logic [3:0]  p1_wmask = '0;
   logic        p0_done, p0_err, p1_done, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;

   int   checks = 0;
   int   errors = 0;
   logic model_last = 1'b1;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_wmask(p0_wmask), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_wmask(p1_wmask), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Runs one access from an IDLE negedge with requests already driven.
   // lat = cycles after mem_req rises before mem_ready is given.
   task automatic do_txn(input int lat, input logic [31:0] rd, input bit drop,
                         output int winner);
      logic        w;
      logic        w_we;
      logic [68:0] ecmd;
      int          n;
      int          exp_n;
      bit          exp_err;
      logic [31:0] exp_rd;
      if (p0_req && p1_req) w = ~model_last;
      else                  w = p1_req;
      model_last = w;
      w_we    = w ? p1_we : p0_we;
      ecmd    = w ? {p1_we, p1_addr, p1_wdata, p1_wmask} : {p0_we, p0_addr, p0_wdata, p0_wmask};
      exp_n   = (lat + 1 < TO) ? lat + 1 : TO;
      exp_err = (lat + 1 > TO);
      exp_rd  = (exp_err || w_we) ? 32'h0 : rd;
      winner  = -1;

      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1) begin
         errors++;
         $display("FAIL mem_req_rise: got %b expected 1", mem_req);
      end
      n = 0;
      while (mem_req === 1'b1 && n < 300) begin
         n++;
         checks++;
         if ({mem_we, mem_addr, mem_wdata, mem_wmask} !== ecmd) begin
            errors++;
            $display("FAIL mem_cmd cycle %0d: got %h expected %h", n,
                     {mem_we, mem_addr, mem_wdata, mem_wmask}, ecmd);
         end
         mem_ready = (n == lat + 1);
         mem_rdata = mem_ready ? rd : $urandom;
         if (drop && n == 1) begin
            if (w) p1_req = 1'b0;
            else   p0_req = 1'b0;
         end
         @(negedge clk);
      end
      mem_ready = 1'b0;

      checks++;
      if (n !== exp_n) begin
         errors++;
         $display("FAIL busy_len: got %0d cycles expected %0d", n, exp_n);
      end
      checks++;
      if ({p0_done, p1_done} !== (w ? 2'b01 : 2'b10)) begin
         errors++;
         $display("FAIL done: got %b expected %b", {p0_done, p1_done}, (w ? 2'b01 : 2'b10));
      end
      checks++;
      if ({p0_err, p1_err} !== (w ? {1'b0, exp_err} : {exp_err, 1'b0})) begin
         errors++;
         $display("FAIL err: got %b expected %b", {p0_err, p1_err},
                  (w ? {1'b0, exp_err} : {exp_err, 1'b0}));
      end
      checks++;
      if ({p0_rdata, p1_rdata} !== (w ? {32'h0, exp_rd} : {exp_rd, 32'h0})) begin
         errors++;
         $display("FAIL rdata: got %h expected %h", {p0_rdata, p1_rdata},
                  (w ? {32'h0, exp_rd} : {exp_rd, 32'h0}));
      end
      winner = p1_done ? 1 : (p0_done ? 0 : -1);
      if (w) p1_req = 1'b0;
      else   p0_req = 1'b0;

      @(negedge clk);
      checks++;
      if ({mem_req, p0_done, p1_done} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_done: got %b expected 000", {mem_req, p0_done, p1_done});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, p0_done, p0_err, p0_rdata,
           p1_done, p1_err, p1_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, p0_done, p0_err,
                   p0_rdata, p1_done, p1_err, p1_rdata});
      end
      rst = 1'b0;
      model_last = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_tie();
      int exp_seq[4] = '{0, 1, 0, 1};
      int w;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h100; p0_wdata = 32'h0; p0_wmask = 4'h0;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h200; p1_wdata = 32'hA5A5A5A5; p1_wmask = 4'h3;
      for (int i = 0; i < 4; i++) begin
         do_txn(1, 32'h1000 + 32'(i), 1'b0, w);
         checks++;
         if (w !== exp_seq[i]) begin
            errors++;
            $display("FAIL tie_order access %0d: got port %0d expected port %0d", i, w, exp_seq[i]);
         end
         if (i < 3) begin
            if (w == 1) p1_req = 1'b1;
            else        p0_req = 1'b1;
         end
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
   endtask

   task automatic test_basic_load();
      int w;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = 32'h0; p0_wmask = 4'h0;
      do_txn(2, 32'hDEADBEEF, 1'b0, w);
      checks++;
      if (w !== 0) begin
         errors++;
         $display("FAIL basic_load_port: got %0d expected 0", w);
      end
   endtask

   task automatic test_store();
      int w;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h12345678; p1_wmask = 4'hF;
      do_txn(3, 32'hCAFEF00D, 1'b0, w);
      checks++;
      if (w !== 1) begin
         errors++;
         $display("FAIL store_port: got %0d expected 1", w);
      end
   endtask

   task automatic test_timeout();
      int w;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h44; p0_wdata = 32'h0; p0_wmask = 4'h0;
      do_txn(100, 32'h55555555, 1'b0, w);
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h48;
      do_txn(TO - 1, 32'h77778888, 1'b0, w);
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h4C;
      do_txn(TO, 32'h9999AAAA, 1'b1, w);
   endtask

   task automatic test_ignore();
      mem_ready = 1'b1;
      mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      mem_ready = 1'b0;
      repeat (2) begin
         checks++;
         if ({mem_req, p0_done, p1_done, p0_rdata, p1_rdata} !== '0) begin
            errors++;
            $display("FAIL idle_ready_ignored: got %h expected 0",
                     {mem_req, p0_done, p1_done, p0_rdata, p1_rdata});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_busy();
      int w;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h60; p1_wdata = 32'h0; p1_wmask = 4'h0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({mem_req, p0_done, p1_done, mem_addr} !== '0) begin
         errors++;
         $display("FAIL reset_mid_busy: got %h expected 0", {mem_req, p0_done, p1_done, mem_addr});
      end
      p1_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_last = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({mem_req, p0_done, p1_done} !== 3'b000) begin
            errors++;
            $display("FAIL no_done_after_reset: got %b expected 000", {mem_req, p0_done, p1_done});
         end
      end
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h64;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h68;
      do_txn(2, 32'h31415926, 1'b0, w);
      checks++;
      if (w !== 0) begin
         errors++;
         $display("FAIL post_reset_grant: got %0d expected 0", w);
      end
      do_txn(0, 32'h27182818, 1'b0, w);
   endtask

   task automatic test_random();
      int w;
      for (int it = 0; it < 40; it++) begin
         if (!p0_req && $urandom_range(0, 1) == 1) begin
            p0_req = 1'b1; p0_we = 1'($urandom); p0_addr = $urandom;
            p0_wdata = $urandom; p0_wmask = 4'($urandom);
         end
         if (!p1_req && $urandom_range(0, 1) == 1) begin
            p1_req = 1'b1; p1_we = 1'($urandom); p1_addr = $urandom;
            p1_wdata = $urandom; p1_wmask = 4'($urandom);
         end
         if (!p0_req && !p1_req) begin
            p0_req = 1'b1; p0_we = 1'($urandom); p0_addr = $urandom;
            p0_wdata = $urandom; p0_wmask = 4'($urandom);
         end
         do_txn($urandom_range(0, 20), $urandom, ($urandom_range(0, 3) == 0), w);
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tie();
      test_basic_load();
      test_store();
      test_timeout();
      test_ignore();
      test_reset_busy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
